// File: rtl/timer_if.sv
// Command and status bundle for the minutes:seconds countdown timer.
// Commands are plain levels sampled on every rising clk edge. There is no
// valid/ready handshake: a command acts on each edge where it is high, and
// status outputs are valid every cycle.
interface timer_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       tick;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] state;
  logic       done;

  modport master (
    output start, stop, clear, load, load_min, load_sec,
    input  tick, min, sec, state, done
  );

  modport slave (
    input  start, stop, clear, load, load_min, load_sec,
    output tick, min, sec, state, done
  );
endinterface

// File: rtl/timer_ctrl.sv
// Minutes:seconds countdown timer. A prescaler divides clk into count ticks;
// each tick decrements the time, and reaching 00:00 raises a one-cycle done.
// Command priority is clear > load > stop > start.
module timer_ctrl #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic   clk,
  input  logic   rst,
  timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  state_t      state_q, state_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [15:0] pre_q, pre_d;
  logic        done_q, done_d;
  logic        tick_w;
  logic [5:0]  dec_min, dec_sec;
  logic        dec_zero;
  logic        time_nonzero;

  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  // Tick marks the last prescaler cycle of a count period while running.
  assign tick_w       = (state_q == RUN) && (pre_q == PRE_LAST);
  assign time_nonzero = (min_q != 6'd0) || (sec_q != 6'd0);

  // Time after one decrement; borrows a minute when seconds are zero.
  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    if (sec_q != 6'd0) begin
      dec_sec = sec_q - 6'd1;
    end else if (min_q != 6'd0) begin
      dec_sec = 6'd59;
      dec_min = min_q - 6'd1;
    end
  end

  assign dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0);

  // Next-state, time and prescaler update with command priority applied.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      min_d   = 6'd0;
      sec_d   = 6'd0;
      pre_d   = 16'd0;
    end else if (bus.load && (state_q != RUN)) begin
      state_d = IDLE;
      min_d   = clamp59(bus.load_min);
      sec_d   = clamp59(bus.load_sec);
      pre_d   = 16'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.stop && bus.start && time_nonzero) begin
            state_d = RUN;
            pre_d   = 16'd0;
          end
        end
        RUN: begin
          if (tick_w) begin
            // The decrement always lands; expiry outranks a coincident stop.
            min_d = dec_min;
            sec_d = dec_sec;
            pre_d = 16'd0;
            if (dec_zero) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else if (bus.stop) begin
              state_d = PAUSE;
            end
          end else if (bus.stop) begin
            state_d = PAUSE;
          end else begin
            pre_d = pre_q + 16'd1;
          end
        end
        PAUSE: begin
          // Prescaler is kept so the partial count period resumes.
          if (!bus.stop && bus.start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous reset overriding every command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      pre_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

  assign bus.tick  = tick_w;
  assign bus.min   = min_q;
  assign bus.sec   = sec_q;
  assign bus.state = state_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with PRESCALE=4. Inputs change 1ns after
// a rising edge and outputs are sampled at that same point, so each sample
// shows the registered result of the preceding edge plus the tick decode.
module tb_timer_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic clk;
  logic rst;
  timer_if bus();

  timer_ctrl #(.PRESCALE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] exp_q[$];
  int total;
  int bad;

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] mk(input logic [1:0] s, input logic [5:0] m,
                                     input logic [5:0] sc, input logic t, input logic d);
    return {s, m, sc, t, d};
  endfunction

  function automatic logic [15:0] obs_now();
    return {bus.state, bus.min, bus.sec, bus.tick, bus.done};
  endfunction

  // Driver tasks.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic c, input logic l, input logic sp, input logic st);
    bus.clear = c;
    bus.load  = l;
    bus.stop  = sp;
    bus.start = st;
  endtask

  task automatic set_load(input logic [5:0] m, input logic [5:0] s);
    bus.load_min = m;
    bus.load_sec = s;
  endtask

  task automatic test_reset();
    logic [15:0] got, e;
    rst = 1'b1;
    cmd(0, 0, 0, 0);
    set_load(6'd0, 6'd0);
    repeat ($urandom_range(2, 5)) cyc();
    exp_q.push_back(mk(S_IDLE, 0, 0, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_hold got=%h exp=%h", got, e); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(S_IDLE, 0, 0, 0, 0));
      cyc();
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_release k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_countdown();
    logic [15:0] got, e;
    set_load(6'd0, 6'd2);
    cmd(0, 1, 0, 0);
    exp_q.push_back(mk(S_IDLE, 0, 2, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL load_0002 got=%h exp=%h", got, e); end
    cmd(0, 0, 0, 0);
    repeat ($urandom_range(0, 3)) cyc();
    cmd(0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8)       exp_q.push_back(mk(S_RUN, 0, (k <= 4) ? 6'd2 : 6'd1, (k == 4 || k == 8), 0));
      else if (k == 9)  exp_q.push_back(mk(S_DONE, 0, 0, 0, 1));
      else              exp_q.push_back(mk(S_DONE, 0, 0, 0, 0));
      cyc();
      if (k == 1) cmd(0, 0, 0, 0);
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL countdown k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_borrow();
    logic [15:0] got, e;
    logic [5:0] m, s;
    cmd(1, 0, 0, 0);
    cyc();
    set_load(6'd1, 6'd0);
    cmd(0, 1, 0, 0);
    exp_q.push_back(mk(S_IDLE, 1, 0, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL load_0100 got=%h exp=%h", got, e); end
    cmd(0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      if (k < 4)       exp_q.push_back(mk(S_RUN, 1, 0, 0, 0));
      else if (k == 4) exp_q.push_back(mk(S_RUN, 1, 0, 1, 0));
      else             exp_q.push_back(mk(S_RUN, 0, 59, 0, 0));
      cyc();
      if (k == 1) begin
        // A load while running must be ignored.
        set_load(6'd5, 6'd5);
        cmd(0, 1, 0, 0);
      end else begin
        cmd(0, 0, 0, 0);
      end
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL borrow k=%0d got=%h exp=%h", k, got, e); end
    end
    cmd(0, 0, 1, 0);
    exp_q.push_back(mk(S_PAUSE, 0, 59, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL borrow_pause got=%h exp=%h", got, e); end
    m = 6'($urandom_range(60, 63));
    s = 6'($urandom_range(60, 63));
    set_load(m, s);
    cmd(0, 1, 0, 0);
    exp_q.push_back(mk(S_IDLE, 59, 59, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL clamp m=%0d s=%0d got=%h exp=%h", m, s, got, e); end
    cmd(0, 0, 0, 0);
  endtask

  task automatic test_pause();
    logic [15:0] got, e;
    cmd(1, 0, 0, 0);
    cyc();
    set_load(6'd0, 6'd3);
    cmd(0, 1, 0, 0);
    cyc();
    cmd(0, 0, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(mk(S_RUN, 0, 3, 0, 0));
      cyc();
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL pause_run k=%0d got=%h exp=%h", k, got, e); end
    end
    cmd(0, 0, 1, 0);
    exp_q.push_back(mk(S_PAUSE, 0, 3, 0, 0));
    cyc();
    cmd(0, 0, 0, 0);
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL pause_enter got=%h exp=%h", got, e); end
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(mk(S_PAUSE, 0, 3, 0, 0));
      cyc();
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL pause_hold k=%0d got=%h exp=%h", k, got, e); end
    end
    cmd(0, 0, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      if (k == 1)      exp_q.push_back(mk(S_RUN, 0, 3, 0, 0));
      else if (k == 2) exp_q.push_back(mk(S_RUN, 0, 3, 1, 0));
      else             exp_q.push_back(mk(S_RUN, 0, 2, 0, 0));
      cyc();
      cmd(0, 0, 0, 0);
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL pause_resume k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_zero_start();
    logic [15:0] got, e;
    cmd(1, 0, 0, 0);
    exp_q.push_back(mk(S_IDLE, 0, 0, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL clear_run got=%h exp=%h", got, e); end
    cmd(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(S_IDLE, 0, 0, 0, 0));
      cyc();
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL zero_start k=%0d got=%h exp=%h", k, got, e); end
    end
    set_load(6'd0, 6'd7);
    cmd(0, 1, 0, 0);
    exp_q.push_back(mk(S_IDLE, 0, 7, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL load_0007 got=%h exp=%h", got, e); end
    set_load(6'd9, 6'd9);
    cmd(1, 1, 0, 1);
    exp_q.push_back(mk(S_IDLE, 0, 0, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL clear_load_start got=%h exp=%h", got, e); end
    cmd(0, 0, 0, 0);
    exp_q.push_back(mk(S_IDLE, 0, 0, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL clear_load_after got=%h exp=%h", got, e); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] got, e;
    set_load(6'd0, 6'd5);
    cmd(0, 1, 0, 0);
    cyc();
    cmd(0, 0, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(mk(S_RUN, 0, (k <= 4) ? 6'd5 : 6'd4, (k == 4), 0));
      cyc();
      cmd(0, 0, 0, 0);
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL mid_run k=%0d got=%h exp=%h", k, got, e); end
    end
    rst = 1'b1;
    exp_q.push_back(mk(S_IDLE, 0, 0, 0, 0));
    cyc();
    rst = 1'b0;
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_mid_run got=%h exp=%h", got, e); end
    exp_q.push_back(mk(S_IDLE, 0, 0, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_mid_after got=%h exp=%h", got, e); end
  endtask

  task automatic test_stop_at_done();
    logic [15:0] got, e;
    set_load(6'd0, 6'd1);
    cmd(0, 1, 0, 0);
    cyc();
    cmd(0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(mk(S_RUN, 0, 1, (k == 4), 0));
      cyc();
      cmd(0, 0, (k == 4), 0);
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL stop_done_run k=%0d got=%h exp=%h", k, got, e); end
    end
    exp_q.push_back(mk(S_DONE, 0, 0, 0, 1));
    cyc();
    cmd(0, 0, 0, 1);
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL stop_at_done got=%h exp=%h", got, e); end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(S_DONE, 0, 0, 0, 0));
      cyc();
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL done_start_ignored k=%0d got=%h exp=%h", k, got, e); end
    end
    set_load(6'd0, 6'd3);
    cmd(0, 1, 0, 0);
    exp_q.push_back(mk(S_IDLE, 0, 3, 0, 0));
    cyc();
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL load_from_done got=%h exp=%h", got, e); end
    cmd(0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(mk(S_RUN, 0, 3, (k == 4), 0));
      cyc();
      cmd(0, 0, (k == 4), 0);
      got = obs_now(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL stop_tick_run k=%0d got=%h exp=%h", k, got, e); end
    end
    exp_q.push_back(mk(S_PAUSE, 0, 2, 0, 0));
    cyc();
    cmd(0, 0, 0, 0);
    got = obs_now(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL stop_on_tick got=%h exp=%h", got, e); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    cmd(0, 0, 0, 0);
    set_load(6'd0, 6'd0);
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_zero_start();
    test_reset_mid_run();
    test_stop_at_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
